// File: rtl/int_alu_pipe.sv
// Two-stage integer ALU pipe: an EX register feeds combinational ALU logic, and a WB register drives the CDB.
// The WB register also acts as a bypass source. The pipe supports flush and counts CDB back-pressure cycles.
module int_alu_pipe #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ROB_IDX     = 5,
  parameter int unsigned PRF_IDX     = 6,
  parameter int unsigned ARF_IDX     = 5,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   iss_valid,
  output logic                   iss_ready,
  input  logic [ROB_IDX-1:0]     iss_rob_id,
  input  logic [PRF_IDX-1:0]     iss_rd_phy,
  input  logic [ARF_IDX-1:0]     iss_rd_arch,
  input  logic                   iss_op1_sel,
  input  logic                   iss_op2_sel,
  input  logic [3:0]             iss_fu_opcode,
  input  logic [XLEN-1:0]        iss_imm,
  input  logic [XLEN-1:0]        iss_rs1_value,
  input  logic [XLEN-1:0]        iss_rs2_value,
  output logic                   cdb_valid,
  input  logic                   cdb_ready,
  output logic [ROB_IDX-1:0]     cdb_rob_id,
  output logic [PRF_IDX-1:0]     cdb_rd_phy,
  output logic [ARF_IDX-1:0]     cdb_rd_arch,
  output logic [XLEN-1:0]        cdb_rd_value,
  output logic                   byp_valid,
  output logic [PRF_IDX-1:0]     byp_rd_phy,
  output logic [XLEN-1:0]        byp_value,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int unsigned SHW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9
  } alu_op_e;

  logic                   r_ex_valid;
  logic [ROB_IDX-1:0]     r_ex_rob_id;
  logic [PRF_IDX-1:0]     r_ex_rd_phy;
  logic [ARF_IDX-1:0]     r_ex_rd_arch;
  logic                   r_ex_op1_sel;
  logic                   r_ex_op2_sel;
  alu_op_e                r_ex_opcode;
  logic [XLEN-1:0]        r_ex_imm;
  logic [XLEN-1:0]        r_ex_rs1;
  logic [XLEN-1:0]        r_ex_rs2;

  logic                   r_wb_valid;
  logic [ROB_IDX-1:0]     r_wb_rob_id;
  logic [PRF_IDX-1:0]     r_wb_rd_phy;
  logic [ARF_IDX-1:0]     r_wb_rd_arch;
  logic [XLEN-1:0]        r_wb_value;

  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic                   w_wb_adv;
  logic                   w_ex_adv;
  logic                   w_iss_fire;
  logic                   w_ex_fire;
  logic [XLEN-1:0]        w_opa;
  logic [XLEN-1:0]        w_opb;
  logic [SHW-1:0]         w_shamt;
  logic [XLEN-1:0]        w_result;

  assign w_wb_adv   = ~r_wb_valid | cdb_ready;
  assign w_ex_adv   = ~r_ex_valid | w_wb_adv;
  assign iss_ready  = w_ex_adv & ~flush;
  assign w_iss_fire = iss_valid & iss_ready;
  assign w_ex_fire  = r_ex_valid & w_wb_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_iss_fire) begin
      r_ex_valid <= 1'b1;
    end else if (w_ex_adv) begin
      r_ex_valid <= 1'b0;
    end
  end

  // Payload registers carry no reset; they are only observed while the matching valid is set.
  always_ff @(posedge clk) begin
    if (w_iss_fire) begin
      r_ex_rob_id  <= iss_rob_id;
      r_ex_rd_phy  <= iss_rd_phy;
      r_ex_rd_arch <= iss_rd_arch;
      r_ex_op1_sel <= iss_op1_sel;
      r_ex_op2_sel <= iss_op2_sel;
      r_ex_opcode  <= alu_op_e'(iss_fu_opcode);
      r_ex_imm     <= iss_imm;
      r_ex_rs1     <= iss_rs1_value;
      r_ex_rs2     <= iss_rs2_value;
    end
  end

  assign w_opa   = r_ex_op1_sel ? '0 : r_ex_rs1;
  assign w_opb   = r_ex_op2_sel ? r_ex_imm : r_ex_rs2;
  assign w_shamt = w_opb[SHW-1:0];

  always_comb begin
    w_result = '0;
    case (r_ex_opcode)
      OP_ADD:  w_result = w_opa + w_opb;
      OP_SUB:  w_result = w_opa - w_opb;
      OP_SLL:  w_result = w_opa << w_shamt;
      OP_SLT:  w_result = {{(XLEN-1){1'b0}}, $signed(w_opa) < $signed(w_opb)};
      OP_SLTU: w_result = {{(XLEN-1){1'b0}}, w_opa < w_opb};
      OP_XOR:  w_result = w_opa ^ w_opb;
      OP_SRL:  w_result = w_opa >> w_shamt;
      OP_SRA:  w_result = $signed(w_opa) >>> w_shamt;
      OP_OR:   w_result = w_opa | w_opb;
      OP_AND:  w_result = w_opa & w_opb;
      default: w_result = '0;
    endcase
    // Writes to x0 are still broadcast so the ROB entry retires, but with a zero value.
    if (r_ex_rd_arch == '0) begin
      w_result = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
    end else if (flush) begin
      r_wb_valid <= 1'b0;
    end else if (w_ex_fire) begin
      r_wb_valid <= 1'b1;
    end else if (cdb_ready) begin
      r_wb_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ex_fire) begin
      r_wb_rob_id  <= r_ex_rob_id;
      r_wb_rd_phy  <= r_ex_rd_phy;
      r_wb_rd_arch <= r_ex_rd_arch;
      r_wb_value   <= w_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_wb_valid && !cdb_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign cdb_valid    = r_wb_valid;
  assign cdb_rob_id   = r_wb_rob_id;
  assign cdb_rd_phy   = r_wb_rd_phy;
  assign cdb_rd_arch  = r_wb_rd_arch;
  assign cdb_rd_value = r_wb_value;

  assign byp_valid    = r_wb_valid;
  assign byp_rd_phy   = r_wb_rd_phy;
  assign byp_value    = r_wb_value;

  assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_int_alu_pipe.sv
// Bench for int_alu_pipe. It runs directed scenarios plus a random run, checked against an in-order queue model.
module tb_int_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        iss_valid;
  logic        iss_ready;
  logic [4:0]  iss_rob_id;
  logic [5:0]  iss_rd_phy;
  logic [4:0]  iss_rd_arch;
  logic        iss_op1_sel;
  logic        iss_op2_sel;
  logic [3:0]  iss_fu_opcode;
  logic [31:0] iss_imm;
  logic [31:0] iss_rs1_value;
  logic [31:0] iss_rs2_value;
  logic        cdb_valid;
  logic        cdb_ready;
  logic [4:0]  cdb_rob_id;
  logic [5:0]  cdb_rd_phy;
  logic [4:0]  cdb_rd_arch;
  logic [31:0] cdb_rd_value;
  logic        byp_valid;
  logic [5:0]  byp_rd_phy;
  logic [31:0] byp_value;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  rob;
    logic [5:0]  phy;
    logic [4:0]  arch;
    logic [31:0] val;
    bit          vis;
  } ent_t;

  // In-flight ops in program order; vis marks the op that is currently visible on the CDB.
  ent_t        q[$];
  int unsigned m_stall = 0;

  always #5 clk = ~clk;

  int_alu_pipe #(
    .XLEN(32), .ROB_IDX(5), .PRF_IDX(6), .ARF_IDX(5), .STALL_CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rob_id(iss_rob_id), .iss_rd_phy(iss_rd_phy), .iss_rd_arch(iss_rd_arch),
    .iss_op1_sel(iss_op1_sel), .iss_op2_sel(iss_op2_sel), .iss_fu_opcode(iss_fu_opcode),
    .iss_imm(iss_imm), .iss_rs1_value(iss_rs1_value), .iss_rs2_value(iss_rs2_value),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
    .cdb_rob_id(cdb_rob_id), .cdb_rd_phy(cdb_rd_phy), .cdb_rd_arch(cdb_rd_arch),
    .cdb_rd_value(cdb_rd_value),
    .byp_valid(byp_valid), .byp_rd_phy(byp_rd_phy), .byp_value(byp_value),
    .stall_cnt(stall_cnt)
  );

  function automatic logic [31:0] ref_alu(input logic [3:0] opc, input logic s1, input logic s2,
                                          input logic [31:0] rs1, input logic [31:0] rs2,
                                          input logic [31:0] imm, input logic [4:0] arch);
    logic [31:0] a, b, r;
    int sh;
    a  = s1 ? 32'd0 : rs1;
    b  = s2 ? imm : rs2;
    sh = int'(b % 32);
    case (opc)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a << sh;
      4'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: r = (a < b) ? 32'd1 : 32'd0;
      4'd5: r = a ^ b;
      4'd6: r = a >> sh;
      4'd7: begin
        r = a >> sh;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      4'd8: r = a | b;
      4'd9: r = a & b;
      default: r = 32'd0;
    endcase
    if (arch == 5'd0) r = 32'd0;
    return r;
  endfunction

  task automatic tick();
    bit   acc, dlv, head_vis;
    ent_t e;
    head_vis = (q.size() > 0) && q[0].vis;
    acc      = iss_valid && !flush && (q.size() < 2 || cdb_ready);
    dlv      = head_vis && cdb_ready;
    if (head_vis && !cdb_ready && m_stall < 65535) m_stall++;
    e.rob  = iss_rob_id;
    e.phy  = iss_rd_phy;
    e.arch = iss_rd_arch;
    e.val  = ref_alu(iss_fu_opcode, iss_op1_sel, iss_op2_sel, iss_rs1_value, iss_rs2_value,
                     iss_imm, iss_rd_arch);
    e.vis  = 1'b0;
    @(posedge clk);
    if (dlv) void'(q.pop_front());
    if (flush) begin
      q.delete();
    end else begin
      if (q.size() > 0) q[0].vis = 1'b1;
      if (acc) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic set_op(input logic [4:0] rob, input logic [5:0] phy, input logic [4:0] arch,
                        input logic [3:0] opc, input logic s1, input logic s2,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    iss_valid     = 1'b1;
    iss_rob_id    = rob;
    iss_rd_phy    = phy;
    iss_rd_arch   = arch;
    iss_fu_opcode = opc;
    iss_op1_sel   = s1;
    iss_op2_sel   = s2;
    iss_rs1_value = rs1;
    iss_rs2_value = rs2;
    iss_imm       = imm;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; cdb_ready = 1'b0;
    set_op(5'd0, 6'd0, 5'd0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    iss_valid = 1'b0;
    #2;
    total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL reset_cdb_valid got=%0b want=0", cdb_valid); end
    total++; if (byp_valid !== 1'b0) begin bad++; $display("FAIL reset_byp_valid got=%0b want=0", byp_valid); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall got=%0d want=0", stall_cnt); end
    total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL reset_iss_ready got=%0b want=1", iss_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    cdb_ready = 1'b1;
    set_op(5'd3, 6'd9, 5'd4, 4'd0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0);
    #1;
    total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL add_iss_ready got=%0b want=1", iss_ready); end
    tick();
    iss_valid = 1'b0;
    #1;
    total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL add_early got=%0b want=0", cdb_valid); end
    tick();
    #1;
    total++; if (cdb_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%0b want=1", cdb_valid); end
    total++; if (cdb_rd_value !== 32'd12) begin bad++; $display("FAIL add_value got=%0h want=c", cdb_rd_value); end
    total++; if ({cdb_rob_id, cdb_rd_phy, cdb_rd_arch} !== {5'd3, 6'd9, 5'd4}) begin
      bad++; $display("FAIL add_tags got=%0d/%0d/%0d want=3/9/4", cdb_rob_id, cdb_rd_phy, cdb_rd_arch); end
    total++; if ({byp_valid, byp_rd_phy, byp_value} !== {1'b1, 6'd9, 32'd12}) begin
      bad++; $display("FAIL add_bypass got=%0b/%0d/%0h want=1/9/c", byp_valid, byp_rd_phy, byp_value); end
    tick();
    #1;
    total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%0b want=0", cdb_valid); end
  endtask

  task automatic test_ops();
    logic [3:0]  opc [4];
    logic        s1  [4];
    logic        s2  [4];
    logic [31:0] rs1 [4];
    logic [31:0] rs2 [4];
    logic [31:0] imm [4];
    logic [31:0] exp [4];
    opc = '{4'd7, 4'd4, 4'd0, 4'd12};
    s1  = '{1'b0, 1'b0, 1'b1, 1'b0};
    s2  = '{1'b1, 1'b0, 1'b1, 1'b0};
    rs1 = '{32'h8000_0000, 32'd1, 32'hDEAD_BEEF, 32'd5};
    rs2 = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'd7};
    imm = '{32'd4, 32'd0, 32'h1234_5000, 32'd0};
    exp = '{32'hF800_0000, 32'd1, 32'h1234_5000, 32'd0};
    cdb_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k < 4) set_op(5'(10 + k), 6'(20 + k), 5'(1 + k), opc[k], s1[k], s2[k], rs1[k], rs2[k], imm[k]);
      else iss_valid = 1'b0;
      #1;
      if (k >= 2 && k <= 5) begin
        total++; if (cdb_valid !== 1'b1 || cdb_rob_id !== 5'(8 + k)) begin
          bad++; $display("FAIL ops_valid_%0d got=%0b/%0d want=1/%0d", k - 2, cdb_valid, cdb_rob_id, 8 + k); end
        total++; if (cdb_rd_value !== exp[k-2]) begin
          bad++; $display("FAIL ops_value_%0d got=%0h want=%0h", k - 2, cdb_rd_value, exp[k-2]); end
      end
      if (k == 6) begin
        total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL ops_drain got=%0b want=0", cdb_valid); end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    cdb_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 0) set_op(5'd1, 6'd1, 5'd1, 4'd0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0);
      else if (k == 1) set_op(5'd2, 6'd2, 5'd2, 4'd0, 1'b0, 1'b0, 32'd2, 32'd2, 32'd0);
      else if (k == 2) set_op(5'd3, 6'd3, 5'd3, 4'd0, 1'b0, 1'b0, 32'd3, 32'd3, 32'd0);
      else if (k == 7) iss_valid = 1'b0;
      if (k == 6) cdb_ready = 1'b1;
      #1;
      if (k <= 1) begin
        total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_%0d got=%0b want=1", k, iss_ready); end
      end
      if (k >= 2 && k <= 5) begin
        total++; if (iss_ready !== 1'b0) begin bad++; $display("FAIL bp_blocked_%0d got=%0b want=0", k, iss_ready); end
        total++; if ({cdb_valid, cdb_rob_id, cdb_rd_value} !== {1'b1, 5'd1, 32'd2}) begin
          bad++; $display("FAIL bp_hold_%0d got=%0b/%0d/%0h want=1/1/2", k, cdb_valid, cdb_rob_id, cdb_rd_value); end
        total++; if (stall_cnt !== 16'(k - 2)) begin
          bad++; $display("FAIL bp_stall_%0d got=%0d want=%0d", k, stall_cnt, k - 2); end
      end
      if (k == 6) begin
        total++; if (stall_cnt !== 16'd4) begin bad++; $display("FAIL bp_stall_total got=%0d want=4", stall_cnt); end
        total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL bp_shift_accept got=%0b want=1", iss_ready); end
      end
      if (k >= 6 && k <= 8) begin
        total++; if ({cdb_valid, cdb_rob_id, cdb_rd_value} !== {1'b1, 5'(k - 5), 32'(2 * (k - 5))}) begin
          bad++; $display("FAIL bp_drain_%0d got=%0b/%0d/%0h want=1/%0d/%0h", k, cdb_valid, cdb_rob_id,
                          cdb_rd_value, k - 5, 2 * (k - 5)); end
      end
      if (k == 9) begin
        total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0b want=0", cdb_valid); end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    cdb_ready = 1'b0;
    set_op(5'd4, 6'd4, 5'd4, 4'd5, 1'b0, 1'b0, 32'hF0, 32'h0F, 32'd0);
    tick();
    set_op(5'd5, 6'd5, 5'd5, 4'd8, 1'b0, 1'b0, 32'hF0, 32'h0F, 32'd0);
    tick();
    set_op(5'd6, 6'd6, 5'd6, 4'd0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0);
    flush = 1'b1;
    #1;
    total++; if (iss_ready !== 1'b0) begin bad++; $display("FAIL flush_iss_ready got=%0b want=0", iss_ready); end
    total++; if ({cdb_valid, cdb_rob_id} !== {1'b1, 5'd4}) begin
      bad++; $display("FAIL flush_pre got=%0b/%0d want=1/4", cdb_valid, cdb_rob_id); end
    tick();
    flush = 1'b0; iss_valid = 1'b0; cdb_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL flush_killed_%0d got=%0b want=0", k, cdb_valid); end
      if (k == 0) begin
        total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL flush_post_ready got=%0b want=1", iss_ready); end
        total++; if (stall_cnt !== 16'd5) begin bad++; $display("FAIL flush_stall got=%0d want=5", stall_cnt); end
      end
      tick();
    end
  endtask

  task automatic test_rd_zero();
    cdb_ready = 1'b1;
    set_op(5'd7, 6'd17, 5'd0, 4'd0, 1'b0, 1'b0, 32'd3, 32'd4, 32'd0);
    tick();
    iss_valid = 1'b0;
    tick();
    #1;
    total++; if ({cdb_valid, cdb_rd_value} !== {1'b1, 32'd0}) begin
      bad++; $display("FAIL rd0_value got=%0b/%0h want=1/0", cdb_valid, cdb_rd_value); end
    total++; if ({cdb_rd_phy, byp_rd_phy, cdb_rob_id} !== {6'd17, 6'd17, 5'd7}) begin
      bad++; $display("FAIL rd0_tags got=%0d/%0d/%0d want=17/17/7", cdb_rd_phy, byp_rd_phy, cdb_rob_id); end
    tick();
  endtask

  task automatic test_reset_mid();
    cdb_ready = 1'b0;
    set_op(5'd8, 6'd8, 5'd3, 4'd0, 1'b0, 1'b0, 32'd10, 32'd20, 32'd0);
    tick();
    iss_valid = 1'b0;
    tick();
    #1;
    total++; if ({cdb_valid, cdb_rob_id, cdb_rd_value} !== {1'b1, 5'd8, 32'd30}) begin
      bad++; $display("FAIL rstmid_pre got=%0b/%0d/%0h want=1/8/1e", cdb_valid, cdb_rob_id, cdb_rd_value); end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if ({cdb_valid, byp_valid} !== 2'b00) begin
      bad++; $display("FAIL rstmid_valid got=%0b/%0b want=0/0", cdb_valid, byp_valid); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rstmid_stall got=%0d want=0", stall_cnt); end
    total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%0b want=1", iss_ready); end
    q.delete();
    m_stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cdb_ready = 1'b1;
    set_op(5'd9, 6'd9, 5'd2, 4'd1, 1'b0, 1'b0, 32'd10, 32'd3, 32'd0);
    tick();
    iss_valid = 1'b0;
    #1;
    total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL rstmid_early got=%0b want=0", cdb_valid); end
    tick();
    #1;
    total++; if ({cdb_valid, cdb_rob_id, cdb_rd_value} !== {1'b1, 5'd9, 32'd7}) begin
      bad++; $display("FAIL rstmid_after got=%0b/%0d/%0h want=1/9/7", cdb_valid, cdb_rob_id, cdb_rd_value); end
    tick();
  endtask

  task automatic test_random();
    bit exp_valid;
    bit exp_ready;
    for (int c = 0; c < 400; c++) begin
      flush     = ($urandom_range(0, 99) < 4);
      cdb_ready = ($urandom_range(0, 99) < 65);
      set_op(5'($urandom), 6'($urandom), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
             4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), $urandom,
             ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom,
             ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom);
      iss_valid = ($urandom_range(0, 99) < 75);
      #1;
      exp_valid = (q.size() > 0) && q[0].vis;
      exp_ready = !flush && (q.size() < 2 || cdb_ready);
      total++; if (iss_ready !== exp_ready) begin
        bad++; $display("FAIL rnd_ready c=%0d got=%0b want=%0b", c, iss_ready, exp_ready); end
      total++; if ({cdb_valid, byp_valid} !== {exp_valid, exp_valid}) begin
        bad++; $display("FAIL rnd_valid c=%0d got=%0b/%0b want=%0b", c, cdb_valid, byp_valid, exp_valid); end
      if (exp_valid) begin
        total++; if ({cdb_rob_id, cdb_rd_phy, cdb_rd_arch, cdb_rd_value} !== {q[0].rob, q[0].phy, q[0].arch, q[0].val}) begin
          bad++; $display("FAIL rnd_result c=%0d got=%0d/%0d/%0d/%0h want=%0d/%0d/%0d/%0h", c, cdb_rob_id,
                          cdb_rd_phy, cdb_rd_arch, cdb_rd_value, q[0].rob, q[0].phy, q[0].arch, q[0].val); end
        total++; if ({byp_rd_phy, byp_value} !== {q[0].phy, q[0].val}) begin
          bad++; $display("FAIL rnd_bypass c=%0d got=%0d/%0h want=%0d/%0h", c, byp_rd_phy, byp_value,
                          q[0].phy, q[0].val); end
      end
      total++; if (stall_cnt !== 16'(m_stall)) begin
        bad++; $display("FAIL rnd_stall c=%0d got=%0d want=%0d", c, stall_cnt, m_stall); end
      tick();
    end
    flush = 1'b0;
    iss_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_ops();
    test_back_to_back();
    test_flush();
    test_rd_zero();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
